if_prefetch_stage: RTL and testbench
====================================

# if_prefetch_stage

Instruction-fetch stage that sits directly upstream of the decode stage and feeds the IF/ID pipeline register. It owns the fetch PC and issues in-order word requests to a variable-latency instruction memory. Returned words are buffered in a small prefetch queue, and the block presents one instruction per cycle with its PC+4. It honours hazard freezes and flushes all queued and in-flight fetches when the execute stage signals a taken branch.

## Interface
- QUEUE_DEPTH, 4: prefetch queue entries; also the cap on in-flight requests. Power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch address after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- freeze  in  1  hazard stall from the hazard-detect unit; holds the current output instruction.
- branchTaken  in  1  taken-branch redirect from execute.
- branchAddr  in  32  branch target; byte address, word-aligned.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; always word-aligned.
- imem_ready  in  1  memory accepts the request when imem_req && imem_ready.
- imem_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rdata  in  32  response word.
- instValid  out  1  instruction/pc outputs are meaningful.
- instruction  out  32  queue head word.
- pc  out  32  queue head address + 4.

## Operation
- State:
  - fetchPC: next address to request.
  - queue of {addr, word}.
  - inflight counter: accepted requests not yet responded, 0..QUEUE_DEPTH.
  - dropCnt: stale responses still to discard.
- Request issue:
  - imem_req = (inflight + occupancy < QUEUE_DEPTH) && !branchTaken && rst.
  - imem_addr = fetchPC.
  - On acceptance: fetchPC += 4 (wraps modulo 2^32), inflight++.
- Response handling:
  - When imem_valid && dropCnt != 0: the word is discarded and dropCnt decrements.
  - Otherwise the word is pushed with its address, and inflight decrements.
  - The credit rule guarantees the queue never overflows. A response with inflight == 0 is a protocol error: it is ignored (assertion in the bench).
- Output:
  - instValid = queue not empty.
  - Head pops when instValid && !freeze.
- Branch, when branchTaken is high:
  - Queue cleared.
  - fetchPC <= branchAddr.
  - No request that cycle.
  - dropCnt <= dropCnt + inflight - (imem_valid ? 1 : 0).
  - inflight <= 0.
  - Any response in that cycle is discarded.
  - Branch wins over freeze and over a simultaneous pop.
- Reset: queue empty, inflight = 0, dropCnt = 0, fetchPC = RESET_PC. instValid, instruction, pc and imem_req are all 0. Reset mid-transaction abandons outstanding responses; the memory is reset together with this block.

## Timing
- Request-to-output latency is memory latency + 1 cycle: a pushed word appears at the output the cycle after imem_valid. There is no same-cycle bypass.
- Sustained throughput is 1 instruction/cycle when memory latency ≤ QUEUE_DEPTH - 1 and freeze is low.
- Queue full with a pop and a push in the same cycle: both happen and occupancy is unchanged.
- Queue empty with freeze high: no effect.
- The first request after a branch issues the cycle after branchTaken.

## Configuration
- Macro: IF_PERF_CNT_EN.
  - Defined: adds output ports fetchCount[31:0] and dropCount[31:0].
    - fetchCount counts pops.
    - dropCount counts discarded responses plus queue entries flushed by a branch.
    - Both counters wrap and reset to 0.
  - Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Package if_pkg: QUEUE_DEPTH and RESET_PC defaults, WORD_W = 32, PC_INC = 4, and a queue-entry struct {addr, word}.
- Sub-module fetch_queue: synchronous FIFO with push, pop, a synchronous flush that takes priority, and empty/count outputs. The top level holds the PC, credit and drop logic.

## Test plan
- Reset, then imem_ready = 1 with a fixed 1-cycle latency and freeze low -> requests at 0x0, 0x4, 0x8, …; outputs pc = 0x4, 0x8, … on consecutive cycles.
- Fixed 3-cycle latency, QUEUE_DEPTH = 4 -> never more than 4 in flight plus queued combined; one instruction per cycle sustained once filled.
- freeze held 5 cycles with a full queue -> imem_req drops; instruction and pc stay stable; no words lost after freeze is released.
- branchTaken with branchAddr = 0x100 while 2 responses are in flight -> both are discarded; the next output is the word from 0x100 with pc = 0x104.
- branchTaken and imem_valid in the same cycle, with freeze also high -> the response is dropped; the next request goes to the target.
- rst driven low mid-stream with 3 words queued -> next cycle instValid = 0 and imem_req = 0; after release the first request is at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch stage.
package if_pkg;

    localparam int unsigned QUEUE_DEPTH_DEFAULT = 4;
    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam int unsigned WORD_W              = 32;
    localparam logic [WORD_W-1:0] PC_INC        = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } queue_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {addr, word} entries; flush beats push and pop.
module fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  queue_entry_t             push_data,
    input  logic                     pop,
    output queue_entry_t             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    queue_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Fetch stage: PC, request credits, stale-response dropping and prefetch queue.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        instValid,
    output logic [31:0] instruction,
    output logic [31:0] pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] dropCount
`endif
);

    localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned DROP_W = 16;

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit;
    logic              empty, accept, resp_stale, resp_push, pop;
    queue_entry_t      head, push_data;

    assign credit     = {1'b0, inflight_q} + {1'b0, count};
    assign imem_req   = (credit < (CNT_W+1)'(QUEUE_DEPTH)) && !branchTaken && rst;
    assign imem_addr  = fetch_pc_q;
    assign accept     = imem_req && imem_ready;

    assign resp_stale = imem_valid && ((drop_cnt_q != '0) || branchTaken);
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_push  = imem_valid && !resp_stale && (inflight_q != '0);
    assign pop        = !empty && !freeze && !branchTaken;

    // Responses return in order, so the next live word belongs to resp_pc_q.
    assign push_data  = '{addr: resp_pc_q, word: imem_rdata};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (branchTaken),
        .push      (resp_push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (branchTaken) begin
            fetch_pc_d = branchAddr;
            resp_pc_d  = branchAddr;
            inflight_d = '0;
            drop_cnt_d = drop_cnt_q + DROP_W'(inflight_q)
                       - DROP_W'(imem_valid && ((drop_cnt_q != '0) || (inflight_q != '0)));
        end else begin
            if (accept)    fetch_pc_d = fetch_pc_q + PC_INC;
            if (resp_push) resp_pc_d  = resp_pc_q + PC_INC;
            inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(resp_push);
            if (imem_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign instValid   = !empty;
    assign instruction = empty ? '0 : head.word;
    assign pc          = empty ? '0 : head.addr + PC_INC;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_q, drop_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            fetch_count_q <= fetch_count_q + 32'(pop);
            // Flushed queue entries count as drops alongside discarded responses.
            drop_count_q  <= drop_count_q + 32'(resp_stale)
                           + (branchTaken ? 32'(count) : 32'd0);
        end
    end

    assign fetchCount = fetch_count_q;
    assign dropCount  = drop_count_q;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: in-order memory model, epoch-based queue model, directed phases.
module tb_if_prefetch_stage;

    localparam int          QD       = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, freeze, branchTaken, imem_ready, imem_valid;
    logic [31:0] branchAddr, imem_rdata;
    logic        imem_req, instValid;
    logic [31:0] imem_addr, instruction, pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCount, dropCount;
`endif

    always #5 clk = ~clk;

    if_prefetch_stage #(
        .QUEUE_DEPTH (QD),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branchTaken (branchTaken),
        .branchAddr  (branchAddr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instValid   (instValid),
        .instruction (instruction),
        .pc          (pc)
`ifdef IF_PERF_CNT_EN
        ,
        .fetchCount  (fetchCount),
        .dropCount   (dropCount)
`endif
    );

    typedef struct { logic [31:0] addr; logic [31:0] word; } ent_t;
    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;

    ent_t        mq[$];
    mreq_t       memq[$];
    logic [31:0] m_pc;
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          model_on = 0;
    int          m_fetch = 0, m_drop = 0;
    int          checks = 0, failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Live outstanding fetches are the memory records from the current epoch.
    function automatic int cur_inflight();
        int n = 0;
        foreach (memq[i]) if (memq[i].epoch == epoch) n++;
        return n;
    endfunction

    function automatic bit exp_req();
        return model_on && (rst === 1'b1) && (branchTaken !== 1'b1)
            && (cur_inflight() + mq.size() < QD);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        mreq_t r;
        bit    acc, resp, stale;
        resp  = (imem_valid === 1'b1);
        stale = 1'b0;
        if (rst !== 1'b1) begin
            mq.delete();
            memq.delete();
            m_pc     = RESET_PC;
            epoch++;
            model_on = 1'b1;
            m_fetch  = 0;
            m_drop   = 0;
        end else if (model_on) begin
            acc = exp_req() && (imem_ready === 1'b1);
            if (resp && memq.size() > 0) begin
                r     = memq.pop_front();
                stale = (r.epoch != epoch);
            end
            if (branchTaken === 1'b1) begin
                m_drop += mq.size() + (resp ? 1 : 0);
                mq.delete();
                m_pc = branchAddr;
                epoch++;
            end else begin
                if (mq.size() > 0 && freeze !== 1'b1) begin
                    void'(mq.pop_front());
                    m_fetch++;
                end
                if (resp) begin
                    if (stale) m_drop++;
                    else       mq.push_back('{r.addr, mem_word(r.addr)});
                end
                if (acc) begin
                    memq.push_back('{m_pc, epoch, cyc + lat});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_on) begin
            check32("instValid", instValid, 32'(mq.size() > 0));
            check32("imem_req", imem_req, 32'(exp_req()));
            if (mq.size() > 0) begin
                check32("instruction", instruction, mq[0].word);
                check32("pc", pc, mq[0].addr + 32'd4);
            end
            if (exp_req()) check32("imem_addr", imem_addr, m_pc);
`ifdef IF_PERF_CNT_EN
            check32("fetchCount", fetchCount, m_fetch);
            check32("dropCount", dropCount, m_drop);
`endif
        end
    end

    task automatic tick(input bit rs = 1, input bit f = 0, input bit br = 0,
                        input logic [31:0] ba = 32'h0, input bit rdy = 1);
        @(posedge clk);
        #1;
        rst         = rs;
        freeze      = f;
        branchTaken = br;
        branchAddr  = ba;
        imem_ready  = rdy;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(memq[0].addr);
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 32'h0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 0; freeze = 0; branchTaken = 0; branchAddr = 0;
        imem_ready = 0; imem_valid = 0; imem_rdata = 0;

        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        @(negedge clk);
        check32("reset_instValid", instValid, 0);
        check32("reset_req", imem_req, 0);

        // 1-cycle latency stream from RESET_PC
        lat = 1;
        tick();
        @(negedge clk);
        check32("first_req", imem_req, 1);
        check32("first_addr", imem_addr, 32'h0);
        tick();
        tick();
        @(negedge clk);
        check32("first_pc", pc, 32'h4);
        check32("first_instr", instruction, 32'hDEAD_0000);
        tick();
        @(negedge clk);
        check32("second_pc", pc, 32'h8);
        check32("second_instr", instruction, 32'hDEAD_0004);
        repeat (12) tick();

        // 3-cycle latency with occasional back-pressure
        lat = 3;
        for (int i = 0; i < 24; i++) tick(1, 0, 0, 0, (i % 5) != 3);

        // freeze with the queue filling up
        lat = 1;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) tick(1, 1);
        @(negedge clk);
        check32("freeze_req_low", imem_req, 0);
        repeat (10) tick();

        // branch while responses are outstanding
        lat = 3;
        repeat (6) tick();
        tick(1, 0, 1, 32'h100);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            if (!found && instValid === 1'b1) begin
                found = 1;
                check32("branch_pc", pc, 32'h104);
                check32("branch_instr", instruction, 32'hDEAD_0100);
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL branch_timeout: got no instValid expected target word within 20 cycles");
        end

        // branch + response + freeze in the same cycle
        lat = 1;
        repeat (5) tick();
        tick(1, 1, 1, 32'h200);
        tick();
        @(negedge clk);
        check32("redirect_req", imem_req, 1);
        check32("redirect_addr", imem_addr, 32'h200);
        repeat (6) tick();

        // PC wraps modulo 2^32
        tick(1, 0, 1, 32'hFFFF_FFF8);
        repeat (4) tick();
        @(negedge clk);
        check32("wrap_pc", pc, 32'h0);
        check32("wrap_instr", instruction, 32'h2152_FFFC);
        repeat (6) tick();

        // reset mid-stream
        repeat (2) tick();
        repeat (2) tick(1, 1);
        tick(0, 1);
        tick(0);
        @(negedge clk);
        check32("midreset_instValid", instValid, 0);
        check32("midreset_req", imem_req, 0);
        tick();
        @(negedge clk);
        check32("postreset_req", imem_req, 1);
        check32("postreset_addr", imem_addr, RESET_PC);
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
